// File: rtl/shapool_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shapool_job_ctrl
// Brief    : Job sequencer between the host serial/daisy pins and the SHA-256
//            pool core: job shift-in, start/halt, success arbitration, readout.
// Revision : 1.0
// ============================================================================
module shapool_job_ctrl #(
    parameter int JOB_BITS   = 352,
    parameter int NONCE_BITS = 32,
    parameter int CNT_W      = 9
) (
    input  logic                  hwclk,
    input  logic                  reset_in,
    input  logic                  data_clk,
    input  logic                  data_in,
    input  logic                  load_sel,
    input  logic                  done_in,
    input  logic                  success_in,
    input  logic                  core_done,
    input  logic                  core_success,
    input  logic [NONCE_BITS-1:0] core_nonce,
    output logic [JOB_BITS-1:0]   job_data,
    output logic                  core_start,
    output logic                  core_halt,
    output logic                  success_oe,
    output logic                  done_out,
    output logic                  data_out,
    output logic                  data_out_en,
    output logic                  status_led
);

    localparam logic [CNT_W-1:0] C_JOB_CNT   = CNT_W'(JOB_BITS);
    localparam logic [CNT_W-1:0] C_NONCE_CNT = CNT_W'(NONCE_BITS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_EXEC = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [JOB_BITS-1:0]   r_job;
    logic [NONCE_BITS-1:0] r_nonce;
    logic                  r_have_result;
    logic                  r_success_oe;

    // data_clk and load_sel carry a third stage for edge detection
    logic [2:0] r_dclk_sync;
    logic [1:0] r_din_sync;
    logic [2:0] r_load_sync;
    logic [1:0] r_done_sync;
    logic [1:0] r_succ_sync;

    logic w_dclk_rise;
    logic w_din;
    logic w_load;
    logic w_load_rise;
    logic w_succ;
    logic w_win;
    logic w_enter_load;
    logic w_enter_done;
    logic w_readout;

    always_ff @(posedge hwclk) begin
        if (!reset_in) begin
            r_dclk_sync <= '0;
            r_din_sync  <= '0;
            r_load_sync <= '0;
            r_done_sync <= '0;
            r_succ_sync <= '1;
        end else begin
            r_dclk_sync <= {r_dclk_sync[1:0], data_clk};
            r_din_sync  <= {r_din_sync[0], data_in};
            r_load_sync <= {r_load_sync[1:0], load_sel};
            r_done_sync <= {r_done_sync[0], done_in};
            r_succ_sync <= {r_succ_sync[0], success_in};
        end
    end

    assign w_dclk_rise = r_dclk_sync[1] & ~r_dclk_sync[2];
    assign w_din       = r_din_sync[1];
    assign w_load      = r_load_sync[1];
    assign w_load_rise = r_load_sync[1] & ~r_load_sync[2];
    assign w_succ      = r_succ_sync[1];

    // A load_sel rise outside LOAD aborts and outranks every EXEC event
    always_comb begin
        w_next     = r_state;
        core_start = 1'b0;
        core_halt  = 1'b0;
        w_win      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!w_load) begin
                    w_next = (r_cnt == C_JOB_CNT) ? ST_ARM : ST_IDLE;
                end
            end
            ST_ARM: begin
                if (w_load_rise) begin
                    w_next = ST_LOAD;
                end else begin
                    core_start = 1'b1;
                    w_next     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_load_rise) begin
                    core_halt = 1'b1;
                    w_next    = ST_LOAD;
                end else if (core_success) begin
                    w_win  = 1'b1;
                    w_next = ST_DONE;
                end else if (!w_succ && !r_success_oe) begin
                    core_halt = 1'b1;
                    w_next    = ST_DONE;
                end else if (core_done) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_load_rise) begin
                    w_next = ST_LOAD;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_enter_load = (w_next == ST_LOAD) && (r_state != ST_LOAD);
    assign w_enter_done = (w_next == ST_DONE) && (r_state != ST_DONE);
    assign w_readout    = (r_state == ST_DONE) && r_have_result && !w_load
                          && (r_cnt < C_NONCE_CNT);

    always_ff @(posedge hwclk) begin
        if (!reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // One counter serves both the job shift-in and the nonce shift-out
    always_ff @(posedge hwclk) begin
        if (!reset_in) begin
            r_cnt <= '0;
        end else if (w_enter_load || w_enter_done) begin
            r_cnt <= '0;
        end else if ((r_state == ST_LOAD) && w_dclk_rise && (r_cnt != C_JOB_CNT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_readout && w_dclk_rise) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge hwclk) begin
        if (!reset_in) begin
            r_job <= '0;
        end else if ((r_state == ST_LOAD) && w_dclk_rise) begin
            r_job <= {r_job[JOB_BITS-2:0], w_din};
        end
    end

    always_ff @(posedge hwclk) begin
        if (!reset_in) begin
            r_nonce <= '0;
        end else if (w_win) begin
            r_nonce <= core_nonce;
        end else if (w_readout && w_dclk_rise) begin
            r_nonce <= {r_nonce[NONCE_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge hwclk) begin
        if (!reset_in) begin
            r_have_result <= 1'b0;
            r_success_oe  <= 1'b0;
        end else if (w_win) begin
            r_have_result <= 1'b1;
            r_success_oe  <= 1'b1;
        end else if (w_next == ST_LOAD) begin
            r_have_result <= 1'b0;
            r_success_oe  <= 1'b0;
        end else if ((r_state == ST_EXEC) && (w_next == ST_DONE)) begin
            r_have_result <= 1'b0;
        end
    end

    assign job_data    = r_job;
    assign success_oe  = r_success_oe;
    assign done_out    = (r_state == ST_DONE) && r_done_sync[1];
    assign data_out_en = w_readout;
    assign data_out    = w_readout && r_nonce[NONCE_BITS-1];
    assign status_led  = (r_state == ST_EXEC);

endmodule
`default_nettype wire
